// File: rtl/dram_responder.sv
// Synchronous DRAM-style responder: word array with pipelined reads, periodic
// refresh stalls signalled through Ready, and a one-cycle protocol-error pulse.
module dram_responder #(
   parameter int unsigned AW   = 10,
   parameter int unsigned LAT  = 2,
   parameter int unsigned REFI = 64,
   parameter int unsigned RCYC = 4
) (
   input  logic        Clk1,
   input  logic        Reset,
   input  logic [15:0] Addr,
   input  logic        RD,
   input  logic        WR,
   input  logic [15:0] DataIn,
   output logic [15:0] DataOut,
   output logic        Valid,
   output logic        Ready,
   output logic        Err
);

   localparam int unsigned CMAX  = (REFI > RCYC) ? REFI : RCYC;
   localparam int unsigned CW    = $clog2(CMAX) + 1;
   localparam int unsigned DEPTH = 1 << AW;

   typedef enum logic {ST_RUN, ST_REFRESH} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            ready_q;
   logic [15:0]     mem_q [DEPTH];
   logic [LAT-1:0]  pv_q;
   logic [15:0]     pd_q [LAT];
   logic            err_q;

   logic [AW-1:0]   addr_c;
   logic            rd_acc_c;
   logic            wr_acc_c;
   logic            err_c;
   logic            unused_addr_c;

   assign addr_c        = Addr[AW-1:0];
   assign unused_addr_c = ^Addr[15:AW];
   assign rd_acc_c      = ready_q & RD & ~WR;
   assign wr_acc_c      = ready_q & WR & ~RD;
   assign err_c         = ready_q & RD & WR;
   assign Ready         = ready_q;

   // Refresh scheduler: Ready high for REFI cycles, then low for RCYC cycles.
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (cnt_q == CW'(REFI - 1)) begin
                  state_q <= ST_REFRESH;
                  ready_q <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_REFRESH: begin
               if (cnt_q == CW'(RCYC - 1)) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= ST_RUN;
               ready_q <= 1'b1;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Array contents survive reset; reset only blocks the write on its edge.
   always_ff @(posedge Clk1) begin
      if (wr_acc_c && !Reset) begin
         mem_q[addr_c] <= DataIn;
      end
   end

   always_ff @(posedge Clk1) begin
      if (Reset) begin
         pv_q <= '0;
      end else begin
         pv_q[0] <= rd_acc_c;
         for (int i = 1; i < int'(LAT); i++) begin
            pv_q[i] <= pv_q[i-1];
         end
      end
   end

   always_ff @(posedge Clk1) begin
      pd_q[0] <= mem_q[addr_c];
      for (int i = 1; i < int'(LAT); i++) begin
         pd_q[i] <= pd_q[i-1];
      end
   end

   // Output stage; DataOut holds the last returned word between pulses.
   always_ff @(posedge Clk1) begin
      if (Reset) begin
         Valid   <= 1'b0;
         DataOut <= 16'h0000;
         err_q   <= 1'b0;
         Err     <= 1'b0;
      end else begin
         Valid <= pv_q[LAT-1];
         if (pv_q[LAT-1]) begin
            DataOut <= pd_q[LAT-1];
         end
         err_q <= err_c;
         Err   <= err_q;
      end
   end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: directed vector table for the key scenarios, then
// randomized traffic compared against a queue-based reference model.
module tb_dram_responder;

   localparam int unsigned AW   = 10;
   localparam int unsigned LAT  = 2;
   localparam int unsigned REFI = 8;
   localparam int unsigned RCYC = 3;
   localparam int          P    = int'(REFI + RCYC);

   logic        Clk1 = 1'b0;
   logic        Reset = 1'b1;
   logic [15:0] Addr = 16'h0;
   logic        RD = 1'b0;
   logic        WR = 1'b0;
   logic [15:0] DataIn = 16'h0;
   logic [15:0] DataOut;
   logic        Valid;
   logic        Ready;
   logic        Err;

   always #5 Clk1 = ~Clk1;

   dram_responder #(.AW(AW), .LAT(LAT), .REFI(REFI), .RCYC(RCYC)) dut (
      .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR),
      .DataIn(DataIn), .DataOut(DataOut), .Valid(Valid), .Ready(Ready), .Err(Err)
   );

   typedef struct {
      logic        rst, rd, wr;
      logic [15:0] addr, din;
      logic        v;
      logic [15:0] d;
      logic        rdy, e;
   } vec_t;

   typedef struct {
      int          due;
      logic [15:0] d;
   } rsp_t;

   int total = 0;
   int bad   = 0;
   vec_t tbl[$];

   // Reference model state: absolute edge count, edges since reset, memory, pending reads.
   int          m_t = 0;
   int          m_e = 0;
   logic [15:0] m_mem [1024];
   bit          m_written [1024];
   rsp_t        m_q[$];
   int          m_err_due = -1;
   logic        m_valid = 1'b0;
   logic [15:0] m_dout = 16'h0;
   logic        m_ready = 1'b1;
   logic        m_err = 1'b0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_edge();
      bit   rdy;
      int   a;
      rsp_t r;
      m_t++;
      if (Reset) begin
         m_q.delete();
         m_e       = 0;
         m_err_due = -1;
         m_valid   = 1'b0;
         m_dout    = 16'h0;
         m_err     = 1'b0;
         m_ready   = 1'b1;
         return;
      end
      rdy = (m_e % P) < int'(REFI);
      a   = int'(Addr[AW-1:0]);
      if (rdy && (RD != WR)) begin
         if (WR) begin
            m_mem[a]     = DataIn;
            m_written[a] = 1'b1;
         end else begin
            r.due = m_t + int'(LAT);
            r.d   = m_mem[a];
            m_q.push_back(r);
         end
      end
      m_err = (m_err_due == m_t);
      if (rdy && RD && WR) m_err_due = m_t + 1;
      m_valid = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == m_t) begin
         m_valid = 1'b1;
         m_dout  = m_q[0].d;
         void'(m_q.pop_front());
      end
      m_e++;
      m_ready = (m_e % P) < int'(REFI);
   endtask

   task automatic drive_cycle(input logic rst, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [15:0] d);
      Reset  = rst;
      RD     = rd;
      WR     = wr;
      Addr   = a;
      DataIn = d;
      @(posedge Clk1);
      model_edge();
      @(negedge Clk1);
   endtask

   task automatic row(input logic rst, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [15:0] din,
                      input logic v, input logic [15:0] d, input logic rdy, input logic e);
      vec_t x;
      x.rst = rst; x.rd = rd; x.wr = wr; x.addr = a; x.din = din;
      x.v = v; x.d = d; x.rdy = rdy; x.e = e;
      tbl.push_back(x);
   endtask

   initial begin
      //   rst rd wr addr     din      v  dout     rdy e
      row(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);  // 0 reset
      row(0, 0, 1, 16'h0005, 16'hBEEF, 0, 16'h0000, 1, 0);  // 1 write BEEF@5
      row(0, 1, 0, 16'h0005, 16'h0000, 0, 16'h0000, 1, 0);  // 2 read 5
      row(0, 0, 1, 16'h0007, 16'h0777, 0, 16'h0000, 1, 0);  // 3 write 0777@7
      row(0, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 1, 0);  // 4 read data returns
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 1, 0);
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 1, 0);
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 1, 0);
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 0, 0);  // 8 refresh begins
      row(0, 1, 0, 16'h0007, 16'h0000, 0, 16'hBEEF, 0, 0);  // 9 held read ignored
      row(0, 1, 0, 16'h0007, 16'h0000, 0, 16'hBEEF, 0, 0);
      row(0, 1, 0, 16'h0007, 16'h0000, 0, 16'hBEEF, 1, 0);
      row(0, 1, 0, 16'h0007, 16'h0000, 0, 16'hBEEF, 1, 0);  // 12 accepted
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'hBEEF, 1, 0);
      row(0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0777, 1, 0);  // 14 single pulse
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0777, 1, 0);
      row(0, 0, 1, 16'h0000, 16'h0010, 0, 16'h0777, 1, 0);  // 16 preload 0..3
      row(0, 0, 1, 16'h0001, 16'h0011, 0, 16'h0777, 1, 0);
      row(0, 0, 1, 16'h0002, 16'h0012, 0, 16'h0777, 1, 0);
      row(0, 0, 1, 16'h0003, 16'h0013, 0, 16'h0777, 0, 0);
      row(0, 1, 1, 16'h0000, 16'hFFFF, 0, 16'h0777, 0, 0);  // 20 RD+WR while stalled
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0777, 0, 0);
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0777, 1, 0);
      row(0, 1, 0, 16'h0000, 16'h0000, 0, 16'h0777, 1, 0);  // 23 pipelined reads
      row(0, 1, 0, 16'h0001, 16'h0000, 0, 16'h0777, 1, 0);
      row(0, 1, 0, 16'h0002, 16'h0000, 1, 16'h0010, 1, 0);
      row(0, 1, 0, 16'h0003, 16'h0000, 1, 16'h0011, 1, 0);
      row(0, 0, 1, 16'h0403, 16'h1234, 1, 16'h0012, 1, 0);  // 27 aliased write
      row(0, 1, 0, 16'h0003, 16'h0000, 1, 16'h0013, 1, 0);
      row(0, 0, 1, 16'h0009, 16'hAAAA, 0, 16'h0013, 1, 0);
      row(0, 1, 1, 16'h0009, 16'h5555, 1, 16'h1234, 0, 0);  // 30 protocol error
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 1);
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 0, 0);
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0);
      row(0, 1, 0, 16'h0009, 16'h0000, 0, 16'h1234, 1, 0);
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0);
      row(0, 0, 0, 16'h0000, 16'h0000, 1, 16'hAAAA, 1, 0);
      row(0, 1, 0, 16'h0009, 16'h0000, 0, 16'hAAAA, 1, 0);  // 37 read then reset
      row(1, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);
      for (int i = 0; i < 7; i++) row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);
      row(0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);  // refresh restarts

      @(negedge Clk1);
      foreach (tbl[i]) begin
         drive_cycle(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
         chk($sformatf("vec%0d Valid", i), 16'(Valid), 16'(tbl[i].v));
         chk($sformatf("vec%0d DataOut", i), DataOut, tbl[i].d);
         chk($sformatf("vec%0d Ready", i), 16'(Ready), 16'(tbl[i].rdy));
         chk($sformatf("vec%0d Err", i), 16'(Err), 16'(tbl[i].e));
      end

      for (int n = 0; n < 2000; n++) begin
         logic        rst, rd, wr;
         logic [15:0] a;
         int          op;
         int          lo;
         rst = ($urandom_range(0, 99) < 2);
         op  = int'($urandom_range(0, 9));
         lo  = int'($urandom_range(0, 15));
         a   = {6'($urandom_range(0, 63)), 6'd0, 4'(lo)};
         rd  = (op <= 3) || (op == 8);
         wr  = (op >= 4 && op <= 8);
         if (rd && !wr && !m_written[lo]) begin
            rd = 1'b0;
            wr = 1'b1;
         end
         drive_cycle(rst, rd, wr, a, 16'($urandom));
         chk($sformatf("rnd%0d Valid", n), 16'(Valid), 16'(m_valid));
         chk($sformatf("rnd%0d DataOut", n), DataOut, m_dout);
         chk($sformatf("rnd%0d Ready", n), 16'(Ready), 16'(m_ready));
         chk($sformatf("rnd%0d Err", n), 16'(Err), 16'(m_err));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
